// File: rtl/multi_ch_serial_out_pkg.sv
// rtl/multi_ch_serial_out_pkg.sv - shared constants for the multi-channel serial generator
package multi_ch_serial_pkg;

    localparam int CTRL_IDLE   = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_START  = 2;
    localparam int CTRL_RSVD   = 3;
    localparam int CTRL_CH_LSB = 4;

    localparam logic MODE_ONE_SHOT = 1'b0;
    localparam logic MODE_REPEAT   = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/multi_ch_serial_out_if.sv
// rtl/multi_ch_serial_out_if.sv - received-byte strobe bus from the UART rx path
interface multi_ch_serial_out_if;

    logic [7:0] i_data;
    logic       i_rx_done_tick;

    modport master (output i_data, output i_rx_done_tick);
    modport slave  (input i_data, input i_rx_done_tick);

endinterface

// File: rtl/multi_ch_serial_out_ch.sv
// rtl/multi_ch_serial_out_ch.sv - one serial channel: pattern shifter with per-bit divider
module serial_ch
    import multi_ch_serial_pkg::*;
#(
    parameter int DATA_BIT = 32,
    parameter int LOW_DIV  = 100,
    parameter int HIGH_DIV = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DATA_BIT-1:0] pattern,
    input  logic [DATA_BIT-1:0] speed,
    input  logic                idle,
    input  logic                mode,
    input  logic                start,
    output logic                serial,
    output logic                bit_tick,
    output logic                done_tick,
    output logic                busy
);

    localparam int IDX_W   = $clog2(DATA_BIT);
    localparam int DIV_MAX = (LOW_DIV > HIGH_DIV) ? LOW_DIV : HIGH_DIV;
    localparam int DIV_W   = $clog2(DIV_MAX);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BIT - 1);
    localparam logic [DIV_W-1:0] LOW_RLD  = DIV_W'(LOW_DIV - 1);
    localparam logic [DIV_W-1:0] HIGH_RLD = DIV_W'(HIGH_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [0:0]          state;
    logic [DATA_BIT-1:0] pat;
    logic [DATA_BIT-1:0] spd;
    logic                idle_lvl;
    logic                mode_r;
    logic [IDX_W-1:0]    bit_idx;
    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    nxt_idx;

    // DATA_BIT need not be a power of two, so the wrap is explicit
    assign nxt_idx = (bit_idx == IDX_LAST) ? '0 : bit_idx + 1'b1;

    // div_cnt counts down to 0 on the last clock of a bit; ticks are set one
    // edge early so the registered pulse lands on that last clock
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pat       <= '0;
            spd       <= '0;
            idle_lvl  <= 1'b0;
            mode_r    <= 1'b0;
            bit_idx   <= '0;
            div_cnt   <= '0;
            serial    <= 1'b0;
            bit_tick  <= 1'b0;
            done_tick <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bit_tick  <= 1'b0;
            done_tick <= 1'b0;
            if (load) begin
                pat      <= pattern;
                spd      <= speed;
                idle_lvl <= idle;
                mode_r   <= mode;
                bit_idx  <= '0;
                div_cnt  <= speed[0] ? HIGH_RLD : LOW_RLD;
                if (start) begin
                    state  <= ST_RUN;
                    serial <= pattern[0];
                    busy   <= 1'b1;
                end else begin
                    state  <= ST_IDLE;
                    serial <= idle;
                    busy   <= 1'b0;
                end
            end else if (state == ST_RUN) begin
                if (div_cnt == '0) begin
                    if (bit_idx == IDX_LAST && mode_r == MODE_ONE_SHOT) begin
                        state  <= ST_IDLE;
                        serial <= idle_lvl;
                        busy   <= 1'b0;
                    end else begin
                        bit_idx <= nxt_idx;
                        div_cnt <= spd[nxt_idx] ? HIGH_RLD : LOW_RLD;
                        serial  <= pat[nxt_idx];
                    end
                end else begin
                    div_cnt <= div_cnt - 1'b1;
                    if (div_cnt == DIV_ONE) begin
                        bit_tick  <= 1'b1;
                        done_tick <= (bit_idx == IDX_LAST);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/multi_ch_serial_out.sv
// rtl/multi_ch_serial_out.sv - packet assembler and CH_NUM independent serial channels
module multi_ch_serial_out
    import multi_ch_serial_pkg::*;
#(
    parameter int DATA_BIT    = 32,
    parameter int CH_NUM      = 4,
    parameter int LOW_DIV     = 100,
    parameter int HIGH_DIV    = 10,
    parameter int TIMEOUT_CLK = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_ch_serial_out_if.slave rx,
    output logic [CH_NUM-1:0]    o_serial_out,
    output logic [CH_NUM-1:0]    o_bit_tick,
    output logic [CH_NUM-1:0]    o_done_tick,
    output logic [CH_NUM-1:0]    o_busy,
    output logic                 o_pkt_err
);

    localparam int PACK_NUM = 2 * DATA_BIT / 8 + 1;
    localparam int SR_W     = 2 * DATA_BIT + 8;
    localparam int BC_W     = $clog2(PACK_NUM);
    localparam int TO_W     = $clog2(TIMEOUT_CLK + 1);

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(PACK_NUM - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLK - 1);

    logic [BC_W-1:0] byte_cnt;
    logic [SR_W-1:0] sr;
    logic [TO_W-1:0] to_cnt;
    logic            commit;
    logic [3:0]      commit_ch;
    logic            pkt_err;

    logic [4:0]      ch_field;
    logic            ch_ok;
    logic [7:0]      ctrl_byte;
    logic            unused_ctrl;

    // channel index is taken from the live control byte so the error pulse
    // and the commit pulse both appear one cycle after its strobe
    assign ch_field = {1'b0, rx.i_data[7:CTRL_CH_LSB]};
    assign ch_ok    = (ch_field < 5'(CH_NUM));

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= '0;
            sr        <= '0;
            to_cnt    <= '0;
            commit    <= 1'b0;
            commit_ch <= '0;
            pkt_err   <= 1'b0;
        end else begin
            commit  <= 1'b0;
            pkt_err <= 1'b0;
            if (rx.i_rx_done_tick) begin
                sr     <= {rx.i_data, sr[SR_W-1:8]};
                to_cnt <= '0;
                if (byte_cnt == BC_LAST) begin
                    byte_cnt  <= '0;
                    commit    <= ch_ok;
                    pkt_err   <= ~ch_ok;
                    commit_ch <= ch_field[3:0];
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (byte_cnt != '0) begin
                if (to_cnt == TO_LAST) begin
                    byte_cnt <= '0;
                    to_cnt   <= '0;
                    pkt_err  <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    assign o_pkt_err   = pkt_err;
    assign ctrl_byte   = sr[SR_W-1 -: 8];
    assign unused_ctrl = ^{ctrl_byte[CTRL_RSVD], ctrl_byte[7:CTRL_CH_LSB]};

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        serial_ch #(
            .DATA_BIT (DATA_BIT),
            .LOW_DIV  (LOW_DIV),
            .HIGH_DIV (HIGH_DIV)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load      (commit && (commit_ch == 4'(g))),
            .pattern   (sr[DATA_BIT-1:0]),
            .speed     (sr[2*DATA_BIT-1:DATA_BIT]),
            .idle      (ctrl_byte[CTRL_IDLE]),
            .mode      (ctrl_byte[CTRL_MODE]),
            .start     (ctrl_byte[CTRL_START]),
            .serial    (o_serial_out[g]),
            .bit_tick  (o_bit_tick[g]),
            .done_tick (o_done_tick[g]),
            .busy      (o_busy[g])
        );
    end

endmodule

// File: tb/tb_multi_ch_serial_out.sv
// tb/tb_multi_ch_serial_out.sv - self-checking bench for multi_ch_serial_out
`timescale 1ns/1ps
module tb_multi_ch_serial_out;

    localparam int LOW  = 100;
    localparam int HIGH = 10;
    localparam int TOUT = 300;

    logic       clk;
    logic       rst;
    logic [3:0] o_serial_out;
    logic [3:0] o_bit_tick;
    logic [3:0] o_done_tick;
    logic [3:0] o_busy;
    logic       o_pkt_err;

    int checks   = 0;
    int failures = 0;
    bit err_seen = 0;

    multi_ch_serial_out_if rx_bus ();

    multi_ch_serial_out #(
        .DATA_BIT    (32),
        .CH_NUM      (4),
        .LOW_DIV     (LOW),
        .HIGH_DIV    (HIGH),
        .TIMEOUT_CLK (TOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx_bus),
        .o_serial_out (o_serial_out),
        .o_bit_tick   (o_bit_tick),
        .o_done_tick  (o_done_tick),
        .o_busy       (o_busy),
        .o_pkt_err    (o_pkt_err)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        logic [31:0] pat;
        logic [31:0] spd;
        logic [7:0]  ctrl;
        logic        err;
        logic [3:0]  busy;
        logic [3:0]  ser;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_bus.i_data         = b;
        rx_bus.i_rx_done_tick = 1'b1;
        step();
        err_seen |= o_pkt_err;
        rx_bus.i_rx_done_tick = 1'b0;
        step();
        err_seen |= o_pkt_err;
    endtask

    // returns in the cycle right after the control-byte strobe
    task automatic send_pkt(input logic [31:0] pat, input logic [31:0] spd, input logic [7:0] ctrl);
        for (int b = 0; b < 4; b++) send_byte(pat[8*b +: 8]);
        for (int b = 0; b < 4; b++) send_byte(spd[8*b +: 8]);
        rx_bus.i_data         = ctrl;
        rx_bus.i_rx_done_tick = 1'b1;
        step();
        rx_bus.i_rx_done_tick = 1'b0;
    endtask

    // expected channel outputs k clocks after the configuration takes effect
    function automatic void exp_at(input logic [31:0] pat, input logic [31:0] spd,
                                   input bit rpt, input bit idl, input int k,
                                   output bit s, output bit bt, output bit dn, output bit by);
        int per, kk, acc, n;
        bit found;
        per = 0;
        for (int b = 0; b < 32; b++) per += spd[b] ? HIGH : LOW;
        s = idl; bt = 0; dn = 0; by = 0; found = 0;
        if (rpt || k < per) begin
            kk  = rpt ? (k % per) : k;
            acc = 0;
            for (int b = 0; b < 32; b++) begin
                n = spd[b] ? HIGH : LOW;
                if (!found && kk < acc + n) begin
                    found = 1;
                    s  = pat[b];
                    bt = (kk == acc + n - 1);
                    dn = bt && (b == 31);
                    by = 1;
                end
                acc += n;
            end
        end
    endfunction

    task automatic run_check(input int ch, input logic [31:0] pat, input logic [31:0] spd,
                             input bit rpt, input bit idl, input int ncyc,
                             input int nbt, input int ndn, input string tag);
        int es = 0, eb = 0, ed = 0, ey = 0, eo = 0, cbt = 0, cdn = 0;
        bit s, bt, dn, by;
        logic [3:0] m, oser;
        m    = ~(4'b0001 << ch);
        oser = o_serial_out & m;
        for (int k = 0; k < ncyc; k++) begin
            exp_at(pat, spd, rpt, idl, k, s, bt, dn, by);
            if (o_serial_out[ch] !== s)  es++;
            if (o_bit_tick[ch]   !== bt) eb++;
            if (o_done_tick[ch]  !== dn) ed++;
            if (o_busy[ch]       !== by) ey++;
            if ((o_serial_out & m) !== oser || (o_busy & m) !== 4'b0 ||
                (o_bit_tick & m) !== 4'b0 || (o_done_tick & m) !== 4'b0) eo++;
            if (o_bit_tick[ch] === 1'b1)  cbt++;
            if (o_done_tick[ch] === 1'b1) cdn++;
            step();
        end
        chk({tag, "_serial_bad_cycles"}, es, 0);
        chk({tag, "_bit_tick_bad_cycles"}, eb, 0);
        chk({tag, "_done_tick_bad_cycles"}, ed, 0);
        chk({tag, "_busy_bad_cycles"}, ey, 0);
        chk({tag, "_other_ch_disturbed"}, eo, 0);
        chk({tag, "_bit_tick_count"}, cbt, nbt);
        chk({tag, "_done_tick_count"}, cdn, ndn);
    endtask

    initial begin
        int first, pulses;

        vt[0] = '{32'h0000_0000, 32'h0, 8'h11, 1'b0, 4'b0000, 4'b0010};
        vt[1] = '{32'h0000_0000, 32'h0, 8'h31, 1'b0, 4'b0000, 4'b1010};
        vt[2] = '{32'hFFFF_FFFF, 32'h0, 8'h54, 1'b1, 4'b0000, 4'b1010};
        vt[3] = '{32'hFFFF_FFFF, 32'h0, 8'hF5, 1'b1, 4'b0000, 4'b1010};
        vt[4] = '{32'h0000_0000, 32'h0, 8'h36, 1'b0, 4'b1000, 4'b0010};
        vt[5] = '{32'h0000_0000, 32'h0, 8'h31, 1'b0, 4'b0000, 4'b1010};
        vt[6] = '{32'h0000_0000, 32'h0, 8'h30, 1'b0, 4'b0000, 4'b0010};
        vt[7] = '{32'h0000_0001, 32'h0, 8'h24, 1'b0, 4'b0100, 4'b0110};
        vt[8] = '{32'h0000_0001, 32'h0, 8'h20, 1'b0, 4'b0000, 4'b0010};
        vt[9] = '{32'h0000_0000, 32'h0, 8'h19, 1'b0, 4'b0000, 4'b0010};

        rst = 1'b1;
        rx_bus.i_data = 8'h00;
        rx_bus.i_rx_done_tick = 1'b0;
        repeat (3) step();
        chk("reset_serial", o_serial_out, 4'b0);
        chk("reset_bit_tick", o_bit_tick, 4'b0);
        chk("reset_done_tick", o_done_tick, 4'b0);
        chk("reset_busy", o_busy, 4'b0);
        chk("reset_pkt_err", o_pkt_err, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            send_pkt(vt[i].pat, vt[i].spd, vt[i].ctrl);
            chk($sformatf("vec%0d_pkt_err_t1", i), o_pkt_err, vt[i].err);
            step();
            chk($sformatf("vec%0d_pkt_err_t2", i), o_pkt_err, 1'b0);
            chk($sformatf("vec%0d_busy", i), o_busy, vt[i].busy);
            chk($sformatf("vec%0d_serial", i), o_serial_out, vt[i].ser);
        end

        // one-shot, all low-speed bits
        send_pkt(32'h00FF_00FF, 32'h0, 8'h04);
        chk("oneshot_pkt_err", o_pkt_err, 1'b0);
        step();
        run_check(0, 32'h00FF_00FF, 32'h0, 0, 0, 3300, 32, 1, "oneshot_ch0");

        // repeat with mixed speeds, idle high
        chk("ch1_idle_high_before_start", o_serial_out[1], 1'b1);
        send_pkt(32'h5500_5500, 32'hFFFF_0000, 8'h17);
        chk("repeat_pkt_err", o_pkt_err, 1'b0);
        step();
        run_check(1, 32'h5500_5500, 32'hFFFF_0000, 1, 1, 3620, 65, 2, "repeat_ch1");
        send_pkt(32'h0, 32'h0, 8'h11);
        step();
        chk("abort_ch1_serial", o_serial_out, 4'b0010);
        chk("abort_ch1_busy", o_busy, 4'b0000);

        // partial packet dropped by timeout
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        first = -1;
        pulses = 0;
        for (int i = 0; i < TOUT + 20; i++) begin
            if (o_pkt_err === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
            step();
        end
        chk("timeout_err_offset", first, TOUT - 1);
        chk("timeout_err_pulses", pulses, 1);
        send_pkt(32'h0000_000F, 32'h0, 8'h24);
        chk("after_timeout_pkt_err", o_pkt_err, 1'b0);
        step();
        run_check(2, 32'h0000_000F, 32'h0, 0, 0, 500, 5, 0, "after_timeout_ch2");

        // a strobe landing in the expiry cycle is kept
        err_seen = 0;
        send_byte(8'hF0);
        for (int i = 0; i < TOUT - 2; i++) begin
            err_seen |= o_pkt_err;
            step();
        end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_pkt_tail: begin
            for (int b = 0; b < 4; b++) send_byte(8'h00);
            rx_bus.i_data = 8'h34;
            rx_bus.i_rx_done_tick = 1'b1;
            step();
            rx_bus.i_rx_done_tick = 1'b0;
        end
        err_seen |= o_pkt_err;
        chk("expiry_strobe_no_err", err_seen, 1'b0);
        step();
        chk("expiry_strobe_ch3_busy", o_busy[3], 1'b1);
        chk("expiry_strobe_ch3_serial", o_serial_out[3], 1'b0);

        // reset in the middle of running channels, coincident with a strobe
        send_pkt(32'hFFFF_FFFF, 32'h0, 8'h06);
        repeat (6) step();
        chk("pre_reset_busy", o_busy, 4'b1101);
        rst = 1'b1;
        rx_bus.i_data = 8'hAB;
        rx_bus.i_rx_done_tick = 1'b1;
        step();
        chk("midrun_reset_serial", o_serial_out, 4'b0);
        chk("midrun_reset_busy", o_busy, 4'b0);
        chk("midrun_reset_bit_tick", o_bit_tick, 4'b0);
        chk("midrun_reset_done_tick", o_done_tick, 4'b0);
        chk("midrun_reset_pkt_err", o_pkt_err, 1'b0);
        rst = 1'b0;
        rx_bus.i_rx_done_tick = 1'b0;
        step();
        chk("post_reset_busy", o_busy, 4'b0);
        send_pkt(32'hFFFF_FFFF, 32'h0, 8'h14);
        chk("post_reset_pkt_err", o_pkt_err, 1'b0);
        step();
        chk("post_reset_ch1_busy", o_busy, 4'b0010);
        chk("post_reset_ch1_serial", o_serial_out, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
